// File: rtl/seq_control_module.sv
// rtl/seq_control_module.sv - letter sequencer driving S/O generators
// Plays up to 8 letters from a latched pattern with a programmable inter-letter gap.
module seq_control_module (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        Start_Sig,
  input  logic [7:0]  Pattern_In,
  input  logic [2:0]  Len_In,
  input  logic [15:0] Gap_In,
  input  logic        S_Done_Sig,
  input  logic        O_Done_Sig,
  input  logic        S_Pin_Out,
  input  logic        O_Pin_Out,
  output logic        S_Start_Sig,
  output logic        O_Start_Sig,
  output logic        Done_Sig,
  output logic        Busy_Sig,
  output logic [2:0]  Letter_Idx,
  output logic        Pin_Out
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_RUN, ST_GAP, ST_DONE, ST_WAIT_REL
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_pattern;
  logic [2:0]  r_len;
  logic [15:0] r_gap;
  logic [15:0] r_gap_cnt;
  logic [2:0]  r_idx;
  logic        r_s_start;
  logic        r_o_start;
  logic        r_done;
  logic        r_busy;

  logic        w_match;
  logic        w_last;
  logic        w_gap_zero;
  logic        w_load;
  logic [2:0]  w_idx_nxt;
  logic [15:0] w_gap_cnt_nxt;
  logic        w_sel_s;
  logic        w_s_start_nxt;
  logic        w_o_start_nxt;
  logic        w_done_nxt;
  logic        w_busy_nxt;

  // Only the done pulse of the generator currently started counts.
  assign w_match    = (r_s_start & S_Done_Sig) | (r_o_start & O_Done_Sig);
  // Length 0 encodes 8, so len-1 wrapping to 7 is exactly the last index.
  assign w_last     = (r_idx == r_len - 3'd1);
  assign w_gap_zero = (r_gap_cnt == 16'd0);
  assign w_load     = (r_state == ST_IDLE) && (w_state_nxt == ST_LOAD);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (Start_Sig) w_state_nxt = ST_LOAD;
      ST_LOAD:     w_state_nxt = Start_Sig ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (!Start_Sig)   w_state_nxt = ST_IDLE;
        else if (w_match) w_state_nxt = w_last ? ST_DONE : ST_GAP;
      end
      ST_GAP: begin
        if (!Start_Sig)      w_state_nxt = ST_IDLE;
        else if (w_gap_zero) w_state_nxt = ST_RUN;
      end
      ST_DONE:     w_state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: if (!Start_Sig) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the transition taken.
  always_comb begin
    w_idx_nxt     = r_idx;
    w_gap_cnt_nxt = r_gap_cnt;
    if (w_load) begin
      w_idx_nxt = 3'd0;
    end else if (r_state == ST_GAP) begin
      if (w_state_nxt == ST_RUN) w_idx_nxt = r_idx + 3'd1;
      else if (!w_gap_zero)      w_gap_cnt_nxt = r_gap_cnt - 16'd1;
    end else if (r_state == ST_RUN && w_state_nxt == ST_GAP) begin
      w_gap_cnt_nxt = (r_gap == 16'd0) ? 16'd0 : r_gap - 16'd1;
    end
    w_sel_s       = r_pattern[w_idx_nxt];
    w_s_start_nxt = (w_state_nxt == ST_RUN) && w_sel_s;
    w_o_start_nxt = (w_state_nxt == ST_RUN) && !w_sel_s;
    w_done_nxt    = (w_state_nxt == ST_DONE);
    w_busy_nxt    = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_RUN) ||
                    (w_state_nxt == ST_GAP)  || (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_pattern <= 8'd0;
      r_len     <= 3'd0;
      r_gap     <= 16'd0;
      r_gap_cnt <= 16'd0;
      r_idx     <= 3'd0;
      r_s_start <= 1'b0;
      r_o_start <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_load) begin
        r_pattern <= Pattern_In;
        r_len     <= Len_In;
        r_gap     <= Gap_In;
      end
      r_gap_cnt <= w_gap_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_s_start <= w_s_start_nxt;
      r_o_start <= w_o_start_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign S_Start_Sig = r_s_start;
  assign O_Start_Sig = r_o_start;
  assign Done_Sig    = r_done;
  assign Busy_Sig    = r_busy;
  assign Letter_Idx  = r_idx;
  assign Pin_Out     = (r_s_start & S_Pin_Out) | (r_o_start & O_Pin_Out);

endmodule

// File: tb/tb_seq_control_module.sv
// tb/tb_seq_control_module.sv - scoreboard bench for seq_control_module
// Expected letter/done events are queued per run; a negedge monitor pops and checks them.
module tb_seq_control_module;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Start_Sig;
  logic [7:0]  Pattern_In;
  logic [2:0]  Len_In;
  logic [15:0] Gap_In;
  logic        S_Done_Sig;
  logic        O_Done_Sig;
  logic        S_Pin_Out;
  logic        O_Pin_Out;
  logic        S_Start_Sig;
  logic        O_Start_Sig;
  logic        Done_Sig;
  logic        Busy_Sig;
  logic [2:0]  Letter_Idx;
  logic        Pin_Out;

  seq_control_module dut (
    .CLK(CLK), .RSTn(RSTn), .Start_Sig(Start_Sig),
    .Pattern_In(Pattern_In), .Len_In(Len_In), .Gap_In(Gap_In),
    .S_Done_Sig(S_Done_Sig), .O_Done_Sig(O_Done_Sig),
    .S_Pin_Out(S_Pin_Out), .O_Pin_Out(O_Pin_Out),
    .S_Start_Sig(S_Start_Sig), .O_Start_Sig(O_Start_Sig),
    .Done_Sig(Done_Sig), .Busy_Sig(Busy_Sig),
    .Letter_Idx(Letter_Idx), .Pin_Out(Pin_Out)
  );

  always #5 CLK = ~CLK;

  // kind: 0 = O letter, 1 = S letter, 2 = run done; gap = required low cycles before it (-1 = none)
  typedef struct {
    int kind;
    int idx;
    int gap;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  fixed_delay = 0;
  bit  inject = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Letter generators: one done pulse per start level after a delay, plus optional spurious pulses.
  initial begin
    int  s_cnt, o_cnt, s_del, o_del;
    bit  s_fired, o_fired, sd, od;
    S_Done_Sig = 0; O_Done_Sig = 0; S_Pin_Out = 0; O_Pin_Out = 0;
    s_cnt = 0; o_cnt = 0; s_fired = 0; o_fired = 0; s_del = 1; o_del = 1;
    forever begin
      @(posedge CLK); #1;
      S_Pin_Out = 1'($urandom_range(0, 1));
      O_Pin_Out = 1'($urandom_range(0, 1));
      sd = 0; od = 0;
      if (S_Start_Sig) begin
        if (!s_fired) begin
          s_cnt++;
          if (s_cnt >= s_del) begin sd = 1; s_fired = 1; end
        end
      end else begin
        s_cnt = 0; s_fired = 0;
        s_del = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 12));
      end
      if (O_Start_Sig) begin
        if (!o_fired) begin
          o_cnt++;
          if (o_cnt >= o_del) begin od = 1; o_fired = 1; end
        end
      end else begin
        o_cnt = 0; o_fired = 0;
        o_del = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 12));
      end
      if (inject) begin
        if (S_Start_Sig && $urandom_range(0, 3) == 0) od = 1;
        if (O_Start_Sig && ($urandom_range(0, 3) == 0 || od)) sd = 1;
      end
      S_Done_Sig = sd;
      O_Done_Sig = od;
    end
  end

  // Monitor: start rising edges and Done pulses pop the scoreboard.
  initial begin
    bit  prev_s, prev_o, prev_done;
    int  low;
    bit  exp_pin;
    ev_t e;
    prev_s = 0; prev_o = 0; prev_done = 0; low = 0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_s = 0; prev_o = 0; prev_done = 0; low = 0;
      end else begin
        chk(!(S_Start_Sig && O_Start_Sig), "onehot_start", {S_Start_Sig, O_Start_Sig}, 0);
        exp_pin = S_Start_Sig ? S_Pin_Out : (O_Start_Sig ? O_Pin_Out : 1'b0);
        chk(Pin_Out === exp_pin, "pin_out", Pin_Out, exp_pin);
        if ((S_Start_Sig && !prev_s) || (O_Start_Sig && !prev_o)) begin
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_start", Letter_Idx, -1);
          end else begin
            e = exp_q.pop_front();
            chk(e.kind == (S_Start_Sig ? 1 : 0), "letter_kind", S_Start_Sig ? 1 : 0, e.kind);
            chk(e.idx == int'(Letter_Idx), "letter_idx", Letter_Idx, e.idx);
            if (e.gap >= 0) chk(low == e.gap, "gap_low_cycles", low, e.gap);
          end
        end
        if (Done_Sig) begin
          chk(!prev_done, "done_width", 2, 1);
          chk(Busy_Sig == 1'b1, "busy_at_done", Busy_Sig, 1);
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk(e.kind == 2, "done_order", 2, e.kind);
          end
        end
        if (!S_Start_Sig && !O_Start_Sig) low++;
        else low = 0;
        prev_s = S_Start_Sig; prev_o = O_Start_Sig; prev_done = Done_Sig;
      end
    end
  end

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  // One run; abort_at >= 0 drops Start_Sig during the gap after that letter.
  task automatic do_run(input logic [7:0] pat, input logic [2:0] len, input logic [15:0] gap,
                        input int abort_at);
    int  n, g, nev, cnt;
    ev_t e;
    n = (len == 3'd0) ? 8 : int'(len);
    g = (gap == 16'd0) ? 1 : int'(gap);
    nev = (abort_at >= 0) ? abort_at + 1 : n;
    for (int i = 0; i < nev; i++) begin
      e.kind = int'(pat[i]); e.idx = i; e.gap = (i == 0) ? -1 : g;
      exp_q.push_back(e);
    end
    if (abort_at < 0) begin
      e.kind = 2; e.idx = 0; e.gap = -1;
      exp_q.push_back(e);
    end
    cyc();
    Pattern_In = pat; Len_In = len; Gap_In = gap; Start_Sig = 1;
    cyc();
    Pattern_In = 8'($urandom); Len_In = 3'($urandom); Gap_In = 16'($urandom_range(0, 30));
    cnt = 0;
    if (abort_at >= 0) begin
      while (!(int'(Letter_Idx) == abort_at && !S_Start_Sig && !O_Start_Sig && Busy_Sig)
             && cnt < 2000) begin
        cyc(); cnt++;
      end
      chk(cnt < 2000, "abort_wait_timeout", cnt, 0);
      cyc(); cyc();
      Start_Sig = 0;
      cyc();
      chk(S_Start_Sig == 0, "abort_s_start", S_Start_Sig, 0);
      chk(O_Start_Sig == 0, "abort_o_start", O_Start_Sig, 0);
      chk(Busy_Sig == 0, "abort_busy", Busy_Sig, 0);
      chk(Done_Sig == 0, "abort_done", Done_Sig, 0);
      repeat (4) cyc();
    end else begin
      while (!Done_Sig && cnt < 2000) begin
        cyc(); cnt++;
      end
      chk(cnt < 2000, "done_timeout", cnt, 0);
      cyc();
      chk(Busy_Sig == 0, "busy_after_done", Busy_Sig, 0);
      chk(Done_Sig == 0, "done_one_cycle", Done_Sig, 0);
      repeat ($urandom_range(0, 3)) cyc();
      Start_Sig = 0;
      cyc(); cyc();
    end
    chk(exp_q.size() == 0, "events_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int cnt;
    ev_t e;
    RSTn = 0; Start_Sig = 0; Pattern_In = 0; Len_In = 0; Gap_In = 0;
    repeat (3) cyc();
    chk(S_Start_Sig == 0, "rst_s_start", S_Start_Sig, 0);
    chk(O_Start_Sig == 0, "rst_o_start", O_Start_Sig, 0);
    chk(Done_Sig == 0, "rst_done", Done_Sig, 0);
    chk(Busy_Sig == 0, "rst_busy", Busy_Sig, 0);
    chk(Letter_Idx == 0, "rst_idx", Letter_Idx, 0);
    chk(Pin_Out == 0, "rst_pin", Pin_Out, 0);
    RSTn = 1;
    repeat (2) cyc();

    fixed_delay = 10;
    do_run(8'b0000_0101, 3'd3, 16'd4, -1);
    fixed_delay = 0;
    do_run(8'hAA, 3'd0, 16'd0, -1);
    inject = 1;
    do_run(8'b0110_1001, 3'd6, 16'd2, -1);
    inject = 0;
    do_run(8'($urandom), 3'd5, 16'd20, 1);
    do_run(8'($urandom), 3'd4, 16'd3, -1);
    for (int r = 0; r < 16; r++) begin
      inject = 1'($urandom_range(0, 1));
      do_run(8'($urandom), 3'($urandom_range(0, 7)), 16'($urandom_range(0, 6)), -1);
    end
    inject = 0;

    // Reset while an O letter is running on index 2.
    for (int i = 0; i < 3; i++) begin
      e.kind = 0; e.idx = i; e.gap = (i == 0) ? -1 : 1;
      exp_q.push_back(e);
    end
    cyc();
    Pattern_In = 8'h00; Len_In = 3'd3; Gap_In = 16'd1; Start_Sig = 1;
    cnt = 0;
    while (!(O_Start_Sig && Letter_Idx == 3'd2) && cnt < 500) begin
      cyc(); cnt++;
    end
    chk(cnt < 500, "reset_wait_timeout", cnt, 0);
    #2;
    RSTn = 0;
    #1;
    chk(S_Start_Sig == 0, "async_rst_s_start", S_Start_Sig, 0);
    chk(O_Start_Sig == 0, "async_rst_o_start", O_Start_Sig, 0);
    chk(Done_Sig == 0, "async_rst_done", Done_Sig, 0);
    chk(Busy_Sig == 0, "async_rst_busy", Busy_Sig, 0);
    chk(Letter_Idx == 0, "async_rst_idx", Letter_Idx, 0);
    chk(Pin_Out == 0, "async_rst_pin", Pin_Out, 0);
    Start_Sig = 0;
    exp_q.delete();
    cyc();
    RSTn = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk(Busy_Sig == 0 && S_Start_Sig == 0 && O_Start_Sig == 0, "idle_after_reset",
          {Busy_Sig, S_Start_Sig, O_Start_Sig}, 0);
    end
    do_run(8'b0000_0010, 3'd2, 16'd1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_control_module.md
SEQ_CONTROL_MODULE -- requirements
Module: seq_control_module

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port RSTn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port Start_Sig, input, 1, level request from top; held high for the whole run, dropped after Done_Sig.
REQ-004 SHALL have port Pattern_In, input, 8, letter pattern, LSB first; bit=1 selects S letter, bit=0 selects O letter; sampled only on run start.
REQ-005 SHALL have port Len_In, input, 3, letter count; 1..7 literal, 0 means 8; sampled only on run start.
REQ-006 SHALL have port Gap_In, input, 16, inter-letter gap in CLK cycles; sampled only on run start.
REQ-007 SHALL have ports S_Done_Sig and O_Done_Sig, input, 1 each, one-cycle done pulses from the S and O letter generators.
REQ-008 SHALL have ports S_Pin_Out and O_Pin_Out, input, 1 each, letter generator pin outputs.
REQ-009 SHALL have ports S_Start_Sig and O_Start_Sig, output, 1 each, registered level starts to the S and O generators.
REQ-010 SHALL have port Done_Sig, output, 1, registered one-cycle pulse at end of a completed run.
REQ-011 SHALL have port Busy_Sig, output, 1, high from run start until Done_Sig pulse or abort, inclusive of Done cycle.
REQ-012 SHALL have port Letter_Idx, output, 3, index of the current letter (0-based).
REQ-013 SHALL have port Pin_Out, output, 1, selected letter pin.

Function
REQ-014 States SHALL be IDLE, LOAD, RUN, GAP, DONE, WAIT_REL.
REQ-015 IDLE: on Start_Sig=1 go to LOAD; LOAD latches Pattern_In, Len_In, Gap_In, clears Letter_Idx, sets Busy_Sig, goes to RUN.
REQ-016 RUN: exactly one of S_Start_Sig/O_Start_Sig SHALL be high, chosen by latched pattern bit [Letter_Idx]; held until the matching done pulse.
REQ-017 Done pulse from the unselected generator SHALL be ignored; simultaneous S and O done pulses SHALL count only the selected one.
REQ-018 On the matching done: start SHALL drop the next cycle; if Letter_Idx = length-1 go to DONE, else go to GAP.
REQ-019 GAP: both starts low for max(Gap,1) cycles (Gap=0 still yields exactly 1 start-low cycle); then Letter_Idx increments and RUN resumes.
REQ-020 Consecutive starts to the same generator SHALL always be separated by at least 1 low cycle.
REQ-021 DONE: Done_Sig high exactly 1 cycle, then WAIT_REL; WAIT_REL holds until Start_Sig=0, then IDLE, Busy_Sig low.
REQ-022 Abort: Start_Sig=0 in LOAD, RUN or GAP SHALL drop both starts next cycle, clear Busy_Sig, return to IDLE, no Done_Sig.
REQ-023 Pin_Out SHALL be S_Pin_Out while S_Start_Sig=1, O_Pin_Out while O_Start_Sig=1, else 0 (never X); combinational from registered selects.
REQ-024 Gap counter SHALL be 16 bits, load Gap_In-1 (or 0 for Gap_In=0), count down to 0, no wrap.
REQ-025 Pattern/length/gap input changes during a run SHALL have no effect until next LOAD.

Reset
REQ-026 RSTn=0 SHALL asynchronously force IDLE, S_Start_Sig=0, O_Start_Sig=0, Done_Sig=0, Busy_Sig=0, Letter_Idx=0, gap counter=0, latched pattern/length/gap=0, Pin_Out=0.
REQ-027 Reset mid-run SHALL leave no pending start; after release the block waits in IDLE for Start_Sig.

Verification
REQ-028 SOS: Pattern=8'b0000_0101, Len=3, Gap=4, generators modelled with 10-cycle done delay -> S, O, S starts in order, 4 start-low cycles between letters, one Done_Sig pulse, Letter_Idx 0,1,2.
REQ-029 Len=0, Pattern=8'hAA, Gap=0 -> 8 letters O,S,O,S,O,S,O,S, exactly 1 low cycle between starts, Done after 8th done pulse.
REQ-030 Inject O_Done_Sig during an S letter and simultaneous S/O done during an O letter -> spurious pulse ignored, sequence unchanged.
REQ-031 Drop Start_Sig during GAP of letter 1 -> starts low next cycle, Busy_Sig=0, no Done_Sig, IDLE; new Start runs from Letter_Idx=0.
REQ-032 Assert RSTn=0 while O_Start_Sig=1 -> all outputs 0 immediately (before next edge); Pin_Out=0 outside RUN throughout.
